// File: rtl/board_pkg.sv
// Shared definitions for the grid-game board controller: cell encodings,
// controller FSM states and the flat-board cell index helper.
package board_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CHECK_H,
        CHECK_V,
        CHECK_D,
        CHECK_A,
        RESOLVE
    } state_t;

    // Cell (r,c) occupies bits [2*idx+1 : 2*idx] of the flat board.
    function automatic int unsigned idx(input int unsigned r,
                                        input int unsigned c,
                                        input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/line_counter.sv
// Combinational run-length counter: starting from an origin cell, counts
// contiguous cells owned by one player along +dir and -dir, each side capped
// at WIN_LEN-1 and stopped at the board edge (no wrap between rows).
module line_counter
    import board_pkg::*;
#(
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int WIN_LEN = 4,
    parameter int IDX_W   = 3,
    localparam int RUN_W  = $clog2(2 * WIN_LEN)
) (
    input  logic [2*ROWS*COLS-1:0] board_i,
    input  logic [IDX_W-1:0]       row_i,
    input  logic [IDX_W-1:0]       col_i,
    input  logic signed [1:0]      dr_i,
    input  logic signed [1:0]      dc_i,
    input  logic [1:0]             player_i,
    output logic [RUN_W-1:0]       run_o
);

    localparam int unsigned COLS_U = COLS;

    int          rf, cf, rb, cb;
    int unsigned fwd, bwd;
    logic        fwd_ok, bwd_ok;

    // Walk outward on both sides; a side stops at the first foreign/empty cell or edge.
    always_comb begin
        fwd    = 0;
        bwd    = 0;
        fwd_ok = 1'b1;
        bwd_ok = 1'b1;
        rf     = 0;
        cf     = 0;
        rb     = 0;
        cb     = 0;
        for (int unsigned k = 1; k < WIN_LEN; k++) begin
            rf = int'(row_i) + int'(k) * int'(dr_i);
            cf = int'(col_i) + int'(k) * int'(dc_i);
            rb = int'(row_i) - int'(k) * int'(dr_i);
            cb = int'(col_i) - int'(k) * int'(dc_i);
            if (fwd_ok && rf >= 0 && rf < ROWS && cf >= 0 && cf < COLS) begin
                if (board_i[2*idx(unsigned'(rf), unsigned'(cf), COLS_U) +: 2] == player_i)
                    fwd++;
                else
                    fwd_ok = 1'b0;
            end else begin
                fwd_ok = 1'b0;
            end
            if (bwd_ok && rb >= 0 && rb < ROWS && cb >= 0 && cb < COLS) begin
                if (board_i[2*idx(unsigned'(rb), unsigned'(cb), COLS_U) +: 2] == player_i)
                    bwd++;
                else
                    bwd_ok = 1'b0;
            end else begin
                bwd_ok = 1'b0;
            end
        end
        run_o = RUN_W'(1 + fwd + bwd);
    end

endmodule

// File: rtl/board_controller.sv
// Clocked board store for the grid game: validates move requests, writes
// markers, alternates turns and runs a one-direction-per-cycle win/draw check
// after each accepted move.
module board_controller
    import board_pkg::*;
#(
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int WIN_LEN = 4,
    parameter int IDX_W   = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             resetGame,
    input  logic                             placeMarker,
    input  logic [IDX_W-1:0]                 selectedRow,
    input  logic [IDX_W-1:0]                 selectedCol,
    output logic [2*ROWS*COLS-1:0]           boardFlat,
    output logic                             curPlayer,
    output logic                             moveAccepted,
    output logic                             moveRejected,
    output logic                             busy,
    output logic                             gameOver,
    output logic [1:0]                       winner,
    output logic [$clog2(ROWS*COLS+1)-1:0]   moveCount
);

    localparam int          CELLS  = ROWS * COLS;
    localparam int          BRD_W  = 2 * CELLS;
    localparam int          MC_W   = $clog2(CELLS + 1);
    localparam int          RUN_W  = $clog2(2 * WIN_LEN);
    localparam int unsigned COLS_U = COLS;

    state_t            state_q,  state_d;
    logic [BRD_W-1:0]  board_q,  board_d;
    logic              player_q, player_d;
    logic              acc_q,    acc_d;
    logic              rej_q,    rej_d;
    logic              over_q,   over_d;
    logic [1:0]        winner_q, winner_d;
    logic [MC_W-1:0]   count_q,  count_d;
    logic              win_q,    win_d;
    logic [IDX_W-1:0]  row_q,    row_d;
    logic [IDX_W-1:0]  col_q,    col_d;
    logic [1:0]        mark_q,   mark_d;

    logic              in_range;
    int unsigned       sel_idx;
    logic [1:0]        sel_cell;
    logic [1:0]        mark_now;
    logic              run_hit;
    logic signed [1:0] dr, dc;
    logic [RUN_W-1:0]  run;

    line_counter #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN),
        .IDX_W   (IDX_W)
    ) u_line_counter (
        .board_i  (board_q),
        .row_i    (row_q),
        .col_i    (col_q),
        .dr_i     (dr),
        .dc_i     (dc),
        .player_i (mark_q),
        .run_o    (run)
    );

    // Direction fed to the shared line counter, selected by check state.
    always_comb begin
        dr = 2'sd0;
        dc = 2'sd1;
        case (state_q)
            CHECK_V: begin dr = 2'sd1; dc = 2'sd0;  end
            CHECK_D: begin dr = 2'sd1; dc = 2'sd1;  end
            CHECK_A: begin dr = 2'sd1; dc = -2'sd1; end
            default: begin dr = 2'sd0; dc = 2'sd1;  end
        endcase
    end

    // Move validation, check sequencing and result resolution.
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        player_d = player_q;
        acc_d    = 1'b0;
        rej_d    = 1'b0;
        over_d   = over_q;
        winner_d = winner_q;
        count_d  = count_q;
        win_d    = win_q;
        row_d    = row_q;
        col_d    = col_q;
        mark_d   = mark_q;

        in_range = (int'(selectedRow) < ROWS) && (int'(selectedCol) < COLS);
        sel_idx  = in_range ? idx(32'(selectedRow), 32'(selectedCol), COLS_U) : 0;
        sel_cell = board_q[2*sel_idx +: 2];
        mark_now = player_q ? CELL_P2 : CELL_P1;
        run_hit  = (int'(run) >= WIN_LEN);

        if (resetGame) begin
            state_d  = IDLE;
            board_d  = '0;
            player_d = 1'b0;
            over_d   = 1'b0;
            winner_d = CELL_EMPTY;
            count_d  = '0;
            win_d    = 1'b0;
            row_d    = '0;
            col_d    = '0;
            mark_d   = CELL_EMPTY;
        end else begin
            if (placeMarker && state_q != IDLE)
                rej_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (placeMarker) begin
                        if (in_range && sel_cell == CELL_EMPTY && !over_q) begin
                            board_d[2*sel_idx +: 2] = mark_now;
                            acc_d   = 1'b1;
                            count_d = count_q + MC_W'(1);
                            row_d   = selectedRow;
                            col_d   = selectedCol;
                            mark_d  = mark_now;
                            win_d   = 1'b0;
                            state_d = CHECK_H;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                end
                CHECK_H: begin win_d = win_q | run_hit; state_d = CHECK_V; end
                CHECK_V: begin win_d = win_q | run_hit; state_d = CHECK_D; end
                CHECK_D: begin win_d = win_q | run_hit; state_d = CHECK_A; end
                CHECK_A: begin win_d = win_q | run_hit; state_d = RESOLVE; end
                RESOLVE: begin
                    if (win_q) begin
                        winner_d = mark_q;
                        over_d   = 1'b1;
                    end else if (count_q == MC_W'(CELLS)) begin
                        over_d   = 1'b1;
                    end else begin
                        player_d = ~player_q;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            board_q  <= '0;
            player_q <= 1'b0;
            acc_q    <= 1'b0;
            rej_q    <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= CELL_EMPTY;
            count_q  <= '0;
            win_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            mark_q   <= CELL_EMPTY;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            player_q <= player_d;
            acc_q    <= acc_d;
            rej_q    <= rej_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            count_q  <= count_d;
            win_q    <= win_d;
            row_q    <= row_d;
            col_q    <= col_d;
            mark_q   <= mark_d;
        end
    end

    assign boardFlat    = board_q;
    assign curPlayer    = player_q;
    assign moveAccepted = acc_q;
    assign moveRejected = rej_q;
    assign busy         = (state_q != IDLE);
    assign gameOver     = over_q;
    assign winner       = winner_q;
    assign moveCount    = count_q;

endmodule

// File: doc/board_controller.md
Name: board_controller

Overview:
- Clocked, parametrised successor of the combinational board store for the M152A grid game.
- Holds an ROWS x COLS board of 2-bit cells and validates each move request.
- Writes accepted markers and alternates turns between two players.
- Runs a multi-cycle win/draw check after every move; sits between the input/debounce logic and the VGA/seven-segment display logic.

Parameters:
- ROWS, 5, board rows (3..8)
- COLS, 5, board columns (3..8)
- WIN_LEN, 4, consecutive markers needed to win (3..min(ROWS,COLS))
- IDX_W, 3, width of row/column index inputs (must satisfy 2^IDX_W >= max(ROWS,COLS))

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- resetGame, input, 1, synchronous board clear, level-sensitive
- placeMarker, input, 1, one-cycle move request pulse
- selectedRow, input, IDX_W, target row
- selectedCol, input, IDX_W, target column
- boardFlat, output, 2*ROWS*COLS, cell (r,c) at bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)]; 00 empty, 01 player 1, 10 player 2
- curPlayer, output, 1, 0 = player 1 to move, 1 = player 2
- moveAccepted, output, 1, one-cycle pulse
- moveRejected, output, 1, one-cycle pulse
- busy, output, 1, high while a check is in progress
- gameOver, output, 1, sticky until reset or resetGame
- winner, output, 2, 00 none, 01 player 1, 10 player 2
- moveCount, output, $clog2(ROWS*COLS+1), markers placed

Behaviour:
- Reset (rst_n low) and resetGame both drive every output and state to zero: board empty, curPlayer 0, pulses 0, busy 0, gameOver 0, winner 00, moveCount 0, FSM in IDLE.
- resetGame has priority over everything and aborts an in-flight check; a placeMarker in the same cycle is dropped with no pulse.
- FSM states: IDLE, CHECK_H, CHECK_V, CHECK_D, CHECK_A, RESOLVE.
- IDLE, placeMarker high: the move is valid when row < ROWS, col < COLS, the cell is 00, and gameOver is 0.
  - Valid at edge t: at t+1 the cell holds curPlayer+1, moveAccepted=1, moveCount increments, busy=1, state goes to CHECK_H; the latched row, col and player are used for the whole check.
  - Invalid at edge t: at t+1 moveRejected=1, no other change, state stays IDLE.
- placeMarker while busy: moveRejected pulse; the request is not queued.
- Each CHECK_x state evaluates one direction in one cycle: horizontal, vertical, diagonal (+r,+c), anti-diagonal (+r,-c).
  - run = 1 + contiguous same-player cells on each side, each side capped at WIN_LEN-1 and bounded by the board edge (no wrap-around).
  - Any run >= WIN_LEN sets a sticky win flag.
- RESOLVE:
  - Win flag set: winner = player, gameOver=1, curPlayer unchanged.
  - Else moveCount == ROWS*COLS: gameOver=1, winner=00 (draw).
  - Else curPlayer toggles.
  - Then busy=0 and state returns to IDLE.
- Latency: accept at t+1, result visible at t+6; next move is accepted from edge t+6 onward.
- Pulses are exactly one cycle wide; moveAccepted and moveRejected are never high together.

Decomposition:
- Shared package board_pkg: cell encodings (CELL_EMPTY, CELL_P1, CELL_P2), the FSM state enum, a cell index function idx(r,c).
- One sub-module, line_counter: combinational; inputs are the flat board, origin, direction deltas and player; output is the capped run length. board_controller instantiates it once and muxes its direction inputs by FSM state.

Test Plan:
- Reset then place (0,0): moveAccepted at t+1, cell0=01, busy for 5 cycles, curPlayer=1 at t+6, moveCount=1.
- Place on occupied (0,0), and place at row=5 with ROWS=5: moveRejected pulse each time; board, curPlayer and moveCount unchanged.
- Player 1 plays (2,0),(2,1),(2,2),(2,3) interleaved with player 2 moves elsewhere: after the 4th P1 move, winner=01 and gameOver=1; any further placeMarker is rejected.
- Anti-diagonal win (0,4),(1,3),(2,2),(3,1) by player 2: winner=10. A 3-in-row touching the right edge plus the left-column cell of the next row must not count as a win (no wrap-around).
- Fill the 5x5 board with no line of 4: after the 25th move gameOver=1, winner=00, moveCount=25.
- resetGame asserted during CHECK_V, and rst_n pulsed low mid-check: board all 00, busy=0, no pulses, FSM back in IDLE next cycle; a new move is then accepted normally.
